// File: rtl/video_timing_gen.sv
// Runtime-reconfigurable raster timing generator: power-up hold-off, valid/ready
// geometry load, and glitch-free geometry switching at frame boundaries.
module video_timing_gen #(
  parameter int CNT_W          = 12,
  parameter int POWERUP_CYCLES = 2700000,
  parameter int PU_W           = 22
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cfg_total_w,
  input  logic [CNT_W-1:0] cfg_total_h,
  input  logic [CNT_W-1:0] cfg_act_w,
  input  logic [CNT_W-1:0] cfg_act_h,
  input  logic [CNT_W-1:0] cfg_hs_start,
  input  logic [CNT_W-1:0] cfg_hs_size,
  input  logic [CNT_W-1:0] cfg_vs_start,
  input  logic [CNT_W-1:0] cfg_vs_size,
  input  logic             cfg_invert,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             running,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CNT_W-1:0] px,
  output logic [CNT_W-1:0] py,
  output logic             line_start,
  output logic             frame_start
);

  // Two guard bits so a three-term sum of CNT_W fields can never wrap.
  localparam int SUM_W = CNT_W + 2;
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [PU_W-1:0]  PU_LAST = PU_W'(POWERUP_CYCLES - 1);

  typedef struct packed {
    logic [CNT_W-1:0] total_w;
    logic [CNT_W-1:0] total_h;
    logic [CNT_W-1:0] act_w;
    logic [CNT_W-1:0] act_h;
    logic [CNT_W-1:0] hs_start;
    logic [CNT_W-1:0] hs_size;
    logic [CNT_W-1:0] vs_start;
    logic [CNT_W-1:0] vs_size;
    logic             invert;
  } geom_t;

  typedef enum logic [1:0] {
    PWRUP    = 2'd0,
    WAIT_CFG = 2'd1,
    RUN      = 2'd2
  } state_t;

  function automatic logic [SUM_W-1:0] ext(input logic [CNT_W-1:0] v);
    return SUM_W'(v);
  endfunction

  function automatic logic is_legal(input geom_t g);
    logic [SUM_W-1:0] h_end;
    logic [SUM_W-1:0] v_end;
    h_end = ext(g.act_w) + ext(g.hs_start) + ext(g.hs_size);
    v_end = ext(g.act_h) + ext(g.vs_start) + ext(g.vs_size);
    return (g.act_w < g.total_w) && (g.act_h < g.total_h) &&
           (g.hs_size != '0) && (g.vs_size != '0) &&
           (h_end <= ext(g.total_w)) && (v_end <= ext(g.total_h));
  endfunction

  // True when c lies in [base+ofs, base+ofs+size).
  function automatic logic in_win(input logic [CNT_W-1:0] c,
                                  input logic [CNT_W-1:0] base,
                                  input logic [CNT_W-1:0] ofs,
                                  input logic [CNT_W-1:0] size);
    logic [SUM_W-1:0] lo;
    logic [SUM_W-1:0] hi;
    lo = ext(base) + ext(ofs);
    hi = lo + ext(size);
    return (ext(c) >= lo) && (ext(c) < hi);
  endfunction

  state_t           state;
  logic [PU_W-1:0]  pu_cnt;
  geom_t            pend;
  logic             pend_vld;
  geom_t            shadow;
  logic [CNT_W-1:0] x_p0;
  logic [CNT_W-1:0] y_p0;

  geom_t cfg_word;
  logic  pend_legal;
  logic  x_last;
  logic  y_last;
  logic  apply_now;
  logic  accept;

  assign cfg_word = {cfg_total_w, cfg_total_h, cfg_act_w, cfg_act_h,
                     cfg_hs_start, cfg_hs_size, cfg_vs_start, cfg_vs_size,
                     cfg_invert};

  assign cfg_ready  = (state != PWRUP) && !pend_vld;
  assign accept     = cfg_valid && cfg_ready;
  assign pend_legal = is_legal(pend);
  assign x_last     = (x_p0 == shadow.total_w - ONE);
  assign y_last     = (y_p0 == shadow.total_h - ONE);
  // A running raster only takes new geometry on its final pixel, so frames are never cut.
  assign apply_now  = pend_vld && pend_legal &&
                      ((state == WAIT_CFG) || ((state == RUN) && x_last && y_last));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= PWRUP;
      pu_cnt      <= '0;
      pend        <= '0;
      pend_vld    <= 1'b0;
      shadow      <= '0;
      x_p0        <= '0;
      y_p0        <= '0;
      cfg_err     <= 1'b0;
      running     <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      de          <= 1'b0;
      px          <= '0;
      py          <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      if (accept) begin
        pend     <= cfg_word;
        pend_vld <= 1'b1;
      end else if (pend_vld && !pend_legal) begin
        pend_vld <= 1'b0;
        cfg_err  <= 1'b1;
      end else if (apply_now) begin
        pend_vld <= 1'b0;
        shadow   <= pend;
      end

      // stage 0: raster counters
      case (state)
        PWRUP: begin
          if (pu_cnt == PU_LAST) state <= WAIT_CFG;
          else                   pu_cnt <= pu_cnt + PU_W'(1);
        end
        WAIT_CFG: begin
          if (apply_now) begin
            state <= RUN;
            x_p0  <= '0;
            y_p0  <= '0;
          end
        end
        RUN: begin
          if (x_last) begin
            x_p0 <= '0;
            y_p0 <= y_last ? '0 : y_p0 + ONE;
          end else begin
            x_p0 <= x_p0 + ONE;
          end
        end
        default: state <= PWRUP;
      endcase

      // stage 1: decoded outputs, one cycle behind the counters
      if (state == RUN) begin
        running     <= 1'b1;
        px          <= x_p0;
        py          <= y_p0;
        de          <= (x_p0 < shadow.act_w) && (y_p0 < shadow.act_h);
        hsync       <= in_win(x_p0, shadow.act_w, shadow.hs_start, shadow.hs_size) ^ shadow.invert;
        vsync       <= in_win(y_p0, shadow.act_h, shadow.vs_start, shadow.vs_size) ^ shadow.invert;
        line_start  <= (x_p0 == '0);
        frame_start <= (x_p0 == '0) && (y_p0 == '0);
      end else begin
        running     <= 1'b0;
        px          <= '0;
        py          <= '0;
        de          <= 1'b0;
        hsync       <= shadow.invert;
        vsync       <= shadow.invert;
        line_start  <= 1'b0;
        frame_start <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: a cycle model pushes the expected output
// word at every clock edge, and it is popped and compared on the following falling edge.
module tb_video_timing_gen;
  localparam int CNT_W = 12;
  localparam int PU    = 100;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [CNT_W-1:0] cfg_total_w, cfg_total_h, cfg_act_w, cfg_act_h;
  logic [CNT_W-1:0] cfg_hs_start, cfg_hs_size, cfg_vs_start, cfg_vs_size;
  logic             cfg_invert;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready, cfg_err, running, hsync, vsync, de;
  logic             line_start, frame_start;
  logic [CNT_W-1:0] px, py;

  video_timing_gen #(.CNT_W(CNT_W), .POWERUP_CYCLES(PU), .PU_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_total_w(cfg_total_w), .cfg_total_h(cfg_total_h),
    .cfg_act_w(cfg_act_w), .cfg_act_h(cfg_act_h),
    .cfg_hs_start(cfg_hs_start), .cfg_hs_size(cfg_hs_size),
    .cfg_vs_start(cfg_vs_start), .cfg_vs_size(cfg_vs_size),
    .cfg_invert(cfg_invert), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_err(cfg_err), .running(running), .hsync(hsync), .vsync(vsync), .de(de),
    .px(px), .py(py), .line_start(line_start), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tw, th, aw, ah, hss, hsz, vss, vsz;
    bit inv;
  } geom_t;

  // Scaled-down rasters keep whole frames short enough to watch end to end.
  localparam geom_t G1   = '{tw: 20, th: 12, aw: 12, ah: 8, hss: 2, hsz: 3, vss: 1, vsz: 2, inv: 1'b1};
  localparam geom_t G2   = '{tw: 16, th: 10, aw: 10, ah: 6, hss: 1, hsz: 4, vss: 2, vsz: 1, inv: 1'b0};
  localparam geom_t G3   = '{tw: 14, th: 9,  aw: 8,  ah: 5, hss: 2, hsz: 4, vss: 1, vsz: 3, inv: 1'b0};
  localparam geom_t BAD1 = '{tw: 20, th: 12, aw: 30, ah: 8, hss: 2, hsz: 3, vss: 1, vsz: 2, inv: 1'b1};
  localparam geom_t BAD2 = '{tw: 20, th: 12, aw: 12, ah: 8, hss: 2, hsz: 3, vss: 1, vsz: 0, inv: 1'b1};
  localparam geom_t BAD3 = '{tw: 4095, th: 20, aw: 10, ah: 8, hss: 4000, hsz: 200, vss: 1, vsz: 2, inv: 1'b0};
  localparam geom_t GZ   = '{default: 0};

  int          n_vec = 0;
  int          n_mis = 0;
  logic [31:0] exp_q[$];
  geom_t       cur_g, m_pd, m_sh;
  int          m_state, m_pu, m_t;
  bit          m_pv;
  bit          dut_acc;
  int          c_de, c_ls, c_fs, c_hs, c_vs, c_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit legal(input geom_t g);
    return g.aw < g.tw && g.ah < g.th && g.hsz > 0 && g.vsz > 0 &&
           g.aw + g.hss + g.hsz <= g.tw && g.ah + g.vss + g.vsz <= g.th;
  endfunction

  task automatic set_word(input geom_t g);
    cur_g        = g;
    cfg_total_w  = CNT_W'(g.tw);
    cfg_total_h  = CNT_W'(g.th);
    cfg_act_w    = CNT_W'(g.aw);
    cfg_act_h    = CNT_W'(g.ah);
    cfg_hs_start = CNT_W'(g.hss);
    cfg_hs_size  = CNT_W'(g.hsz);
    cfg_vs_start = CNT_W'(g.vss);
    cfg_vs_size  = CNT_W'(g.vsz);
    cfg_invert   = g.inv;
  endtask

  task automatic m_reset();
    m_state = 0;
    m_pu    = 0;
    m_t     = 0;
    m_pv    = 1'b0;
    m_pd    = GZ;
    m_sh    = GZ;
  endtask

  // Model of one clock edge; m_t is the pixel index within the current frame.
  task automatic m_step();
    int x, y, w, h;
    bit e_run, e_de, e_hs, e_vs, e_ls, e_fs, e_rdy, e_err, rdy_pre, fend;
    logic [CNT_W-1:0] e_px, e_py;
    if (!rst_n) begin
      m_reset();
      exp_q.push_back(32'd0);
      return;
    end
    w = m_sh.tw;
    h = m_sh.th;
    e_run = 0; e_de = 0; e_ls = 0; e_fs = 0; e_px = '0; e_py = '0;
    e_hs = m_sh.inv;
    e_vs = m_sh.inv;
    if (m_state == 2) begin
      x = m_t % w;
      y = m_t / w;
      e_run = 1;
      e_px  = CNT_W'(x);
      e_py  = CNT_W'(y);
      e_de  = (x < m_sh.aw) && (y < m_sh.ah);
      e_hs  = ((x >= m_sh.aw + m_sh.hss) && (x < m_sh.aw + m_sh.hss + m_sh.hsz)) ^ m_sh.inv;
      e_vs  = ((y >= m_sh.ah + m_sh.vss) && (y < m_sh.ah + m_sh.vss + m_sh.vsz)) ^ m_sh.inv;
      e_ls  = (x == 0);
      e_fs  = (m_t == 0);
    end
    e_err   = m_pv && !legal(m_pd);
    rdy_pre = (m_state != 0) && !m_pv;
    fend    = (m_state == 2) && (m_t == w * h - 1);
    if (m_state == 0) begin
      m_pu++;
      if (m_pu == PU) m_state = 1;
    end else if (m_state == 2) begin
      m_t = fend ? 0 : m_t + 1;
    end
    if (m_pv) begin
      if (!legal(m_pd)) m_pv = 1'b0;
      else if (m_state == 1) begin
        m_sh = m_pd; m_pv = 1'b0; m_state = 2; m_t = 0;
      end else if (fend) begin
        m_sh = m_pd; m_pv = 1'b0;
      end
    end else if (cfg_valid && rdy_pre) begin
      m_pd = cur_g;
      m_pv = 1'b1;
    end
    e_rdy = (m_state != 0) && !m_pv;
    exp_q.push_back({e_run, e_de, e_hs, e_vs, e_ls, e_fs, e_rdy, e_err, e_px, e_py});
  endtask

  task automatic tick();
    logic [31:0] got, ev;
    dut_acc = cfg_valid && cfg_ready && rst_n;
    @(posedge clk);
    m_step();
    @(negedge clk);
    got = {running, de, hsync, vsync, line_start, frame_start, cfg_ready, cfg_err, px, py};
    ev  = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    chk("raster", got, ev);
    c_de  += int'(de);
    c_ls  += int'(line_start);
    c_fs  += int'(frame_start);
    c_hs  += int'(hsync);
    c_vs  += int'(vsync);
    c_err += int'(cfg_err);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic clr();
    c_de = 0; c_ls = 0; c_fs = 0; c_hs = 0; c_vs = 0; c_err = 0;
  endtask

  task automatic send(input geom_t g);
    set_word(g);
    cfg_valid = 1'b1;
    dut_acc   = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (dut_acc) break;
    end
    cfg_valid = 1'b0;
    chk("accept", 32'(dut_acc), 32'd1);
  endtask

  initial begin
    set_word(G1);
    m_reset();
    clr();
    run(3);
    rst_n = 1'b1;

    // Power-up hold-off with cfg_valid held, then first geometry.
    send(G1);
    run(300);
    clr();
    run(240);
    chk("g1_de_cycles", 32'(c_de), 32'd96);
    chk("g1_lines", 32'(c_ls), 32'd12);
    chk("g1_frames", 32'(c_fs), 32'd1);

    // Mid-frame switch, with a second word queued behind it.
    run(37);
    send(G2);
    send(G3);
    run(400);

    // Illegal words leave the running raster untouched.
    clr();
    send(BAD1);
    run(4);
    chk("err_pulses", 32'(c_err), 32'd1);
    chk("ready_back", 32'(cfg_ready), 32'd1);
    send(BAD2);
    send(BAD3);
    run(20);

    // G3 fills horizontal and vertical blanking exactly.
    clr();
    run(126);
    chk("g3_hs_cycles", 32'(c_hs), 32'd36);
    chk("g3_vs_cycles", 32'(c_vs), 32'd42);
    chk("g3_de_cycles", 32'(c_de), 32'd40);

    // Asynchronous reset in the middle of a frame.
    for (int i = 0; i < 500 && py != CNT_W'(5); i++) tick();
    chk("reach_py", 32'(py), 32'd5);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", {running, de, hsync, vsync, line_start, frame_start,
                         cfg_ready, cfg_err, px, py}, 32'd0);
    run(2);
    rst_n = 1'b1;
    run(PU - 1);
    chk("pwrup_ready_lo", 32'(cfg_ready), 32'd0);
    run(1);
    chk("pwrup_ready_hi", 32'(cfg_ready), 32'd1);
    send(G1);
    run(300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
